fetch_seq: RTL and testbench

- Instruction-fetch sequencer for the miniRV-1 core.
- Owns the PC register and computes next-PC on redirects using the pipeline's npc_op encoding. Supported ops: PC+4, PC+IMM, JALR with LSB cleared.
- Issues req/ack fetches to instruction memory and presents each fetched instruction downstream under a valid/ready handshake.
- Sits between IROM and the decode stage; the redirect inputs come from execute.

---
 rtl/fetch_seq.sv | 141 ++++++++++++++
 tb/tb_fetch_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, issues req/ack fetches to IROM and
// hands each instruction to decode under valid/ready. Optional: FETCH_MISALIGN_TRAP_EN.
module fetch_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   input  logic [1:0]  redirect_op_i,
   input  logic [31:0] redirect_pc_i,
   input  logic [31:0] redirect_imm_i,
   output logic        if_req_o,
   output logic [31:0] if_addr_o,
   input  logic        if_ack_i,
   input  logic [31:0] if_inst_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   input  logic        inst_ready_i,
   output logic        misalign_o
);

   localparam int unsigned XLEN = 32;

   // npc_op values shared with the execute stage (PC_ADD_IMM / PC_IMM_JALR)
   localparam logic [1:0] NPC_ADD_IMM = 2'd1;
   localparam logic [1:0] NPC_JALR    = 2'd2;

   typedef enum logic [1:0] {IDLE, REQ, OUT, TRAP} state_t;

   state_t            state, state_nxt;
   logic [XLEN-1:0]   pc, pc_nxt;
   logic              drop, drop_nxt;
   logic [XLEN-1:0]   inst_q, inst_nxt;
   logic [XLEN-1:0]   inst_pc_q, inst_pc_nxt;
   logic [XLEN-1:0]   sum;
   logic [XLEN-1:0]   target;
   logic [XLEN-1:0]   pc_inc;

   // Redirect target and sequential increment, both wrapping modulo 2^32
   always_comb begin
      sum    = redirect_pc_i + redirect_imm_i;
      pc_inc = pc + XLEN'(4);
      case (redirect_op_i)
         NPC_JALR:    target = {sum[XLEN-1:1], 1'b0};
         NPC_ADD_IMM: target = sum;
         default:     target = redirect_pc_i + XLEN'(4);
      endcase
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_q, misalign_nxt;
   logic bad_target;
   assign bad_target = redirect_valid_i && (target[1:0] != 2'b00) && (state != TRAP);
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         drop      <= 1'b0;
         inst_q    <= '0;
         inst_pc_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         drop      <= drop_nxt;
         inst_q    <= inst_nxt;
         inst_pc_q <= inst_pc_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_q <= misalign_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      drop_nxt    = drop;
      inst_nxt    = inst_q;
      inst_pc_nxt = inst_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_nxt = misalign_q;
`endif
      case (state)
         IDLE: begin
            if (redirect_valid_i) pc_nxt = target;
            if (!stall_i) state_nxt = REQ;
         end
         REQ: begin
            // A redirect without an ack leaves one stale response in flight
            if (redirect_valid_i) begin
               pc_nxt   = target;
               drop_nxt = !if_ack_i;
            end else if (if_ack_i) begin
               if (drop) begin
                  drop_nxt = 1'b0;
               end else begin
                  inst_nxt    = if_inst_i;
                  inst_pc_nxt = pc;
                  pc_nxt      = pc_inc;
                  state_nxt   = OUT;
               end
            end
         end
         OUT: begin
            if (redirect_valid_i) begin
               pc_nxt    = target;
               state_nxt = stall_i ? IDLE : REQ;
            end else if (inst_ready_i) begin
               state_nxt = stall_i ? IDLE : REQ;
            end
         end
         default: begin
         end
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      if (bad_target) begin
         state_nxt    = TRAP;
         drop_nxt     = 1'b0;
         misalign_nxt = 1'b1;
      end
`endif
   end

   assign if_req_o     = (state == REQ);
   assign if_addr_o    = pc;
   assign inst_valid_o = (state == OUT);
   assign inst_o       = inst_q;
   assign inst_pc_o    = inst_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign misalign_o   = misalign_q;
`else
   assign misalign_o   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed scenarios plus random traffic against a
// transaction-level model of the fetch/hold/discard behaviour.
module tb_fetch_seq;

   localparam logic [1:0] OP_ADD  = 2'd1;
   localparam logic [1:0] OP_JALR = 2'd2;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        stall_i = 1'b0;
   logic        redirect_valid_i = 1'b0;
   logic [1:0]  redirect_op_i = 2'd0;
   logic [31:0] redirect_pc_i = '0;
   logic [31:0] redirect_imm_i = '0;
   logic        if_req_o;
   logic [31:0] if_addr_o;
   logic        if_ack_i = 1'b0;
   logic [31:0] if_inst_i = '0;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_ready_i = 1'b0;
   logic        misalign_o;

   fetch_seq #(.RESET_PC(32'h0000_0000)) dut (
      .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i),
      .redirect_valid_i(redirect_valid_i), .redirect_op_i(redirect_op_i),
      .redirect_pc_i(redirect_pc_i), .redirect_imm_i(redirect_imm_i),
      .if_req_o(if_req_o), .if_addr_o(if_addr_o),
      .if_ack_i(if_ack_i), .if_inst_i(if_inst_i),
      .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
      .inst_ready_i(inst_ready_i), .misalign_o(misalign_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: a fetch in flight, a held instruction, a stale response to discard
   logic [31:0] m_pc, m_inst, m_inst_pc;
   bit m_fetching, m_holding, m_discard, m_trapped, m_mis;

   function automatic logic [31:0] irom_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_inst = 32'h0; m_inst_pc = 32'h0;
      m_fetching = 0; m_holding = 0; m_discard = 0; m_trapped = 0; m_mis = 0;
   endtask

   task automatic model_edge();
      logic [31:0] tgt;
      if (redirect_op_i == OP_JALR)     tgt = (redirect_pc_i + redirect_imm_i) & 32'hFFFF_FFFE;
      else if (redirect_op_i == OP_ADD) tgt = redirect_pc_i + redirect_imm_i;
      else                              tgt = redirect_pc_i + 32'd4;
      if (m_trapped) begin
      end else if (redirect_valid_i) begin
`ifdef FETCH_MISALIGN_TRAP_EN
         if (tgt % 4 != 0) begin
            m_trapped = 1; m_mis = 1;
            m_fetching = 0; m_holding = 0; m_discard = 0;
            return;
         end
`endif
         m_pc = tgt;
         if (m_fetching) m_discard = !if_ack_i;
         else begin
            m_holding  = 0;
            m_fetching = !stall_i;
         end
      end else if (m_fetching) begin
         if (if_ack_i) begin
            if (m_discard) m_discard = 0;
            else begin
               m_inst = irom_word(m_pc); m_inst_pc = m_pc; m_pc = m_pc + 32'd4;
               m_fetching = 0; m_holding = 1;
            end
         end
      end else if (m_holding) begin
         if (inst_ready_i) begin
            m_holding = 0; m_fetching = !stall_i;
         end
      end else begin
         m_fetching = !stall_i;
      end
   endtask

   task automatic compare_all();
      check("if_req", 32'(if_req_o), 32'(m_fetching));
      if (m_fetching) check("if_addr", if_addr_o, m_pc);
      check("inst_valid", 32'(inst_valid_o), 32'(m_holding));
      if (m_holding) begin
         check("inst", inst_o, m_inst);
         check("inst_pc", inst_pc_o, m_inst_pc);
      end
      check("misalign", 32'(misalign_o), 32'(m_mis));
   endtask

   task automatic step();
      if_inst_i = irom_word(if_addr_o);
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic apply_reset();
      rst_i = 1'b1;
      redirect_valid_i = 1'b0;
      model_reset();
      #1;
      check("rst_req", 32'(if_req_o), 32'h0);
      check("rst_valid", 32'(inst_valid_o), 32'h0);
      check("rst_inst", inst_o, 32'h0);
      check("rst_inst_pc", inst_pc_o, 32'h0);
      check("rst_misalign", 32'(misalign_o), 32'h0);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
   endtask

   initial begin
      #2;
      apply_reset();

      // Back-to-back fetches with same-cycle ack
      stall_i = 0; if_ack_i = 1; inst_ready_i = 1;
      step(); check("t1_addr0", if_addr_o, 32'h0);
      step(); check("t1_pc0", inst_pc_o, 32'h0);
      step(); check("t1_addr4", if_addr_o, 32'h4);
      step(); check("t1_pc4", inst_pc_o, 32'h4);
      step(); check("t1_addr8", if_addr_o, 32'h8);

      // Redirect while a fetch is pending: stale ack dropped
      if_ack_i = 0; redirect_valid_i = 1; redirect_op_i = OP_ADD;
      redirect_pc_i = 32'h10; redirect_imm_i = 32'h20;
      step(); check("t3_addr", if_addr_o, 32'h30);
      redirect_valid_i = 0; if_ack_i = 1;
      step(); check("t3_drop", 32'(inst_valid_o), 32'h0);
      step(); check("t3_pc", inst_pc_o, 32'h30);

      // Delayed ack holds request and address
      apply_reset();
      if_ack_i = 0; stall_i = 0; inst_ready_i = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t2_req", 32'(if_req_o), 32'h1);
         check("t2_addr", if_addr_o, 32'h0);
      end
      if_ack_i = 1;
      step(); check("t2_inst", inst_o, irom_word(32'h0));

      // Backpressure, then stall into IDLE
      if_ack_i = 0; inst_ready_i = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t5_pc", inst_pc_o, 32'h0);
         check("t5_noreq", 32'(if_req_o), 32'h0);
      end
      inst_ready_i = 1; stall_i = 1;
      step(); check("t5_idle", 32'(inst_valid_o) | 32'(if_req_o), 32'h0);
      inst_ready_i = 0;
      step(); step(); check("t5_stall", 32'(if_req_o), 32'h0);
      stall_i = 0;
      step(); check("t5_addr4", if_addr_o, 32'h4);

      // JALR to a target with bit 1 set
      redirect_valid_i = 1; redirect_op_i = OP_JALR;
      redirect_pc_i = 32'h100; redirect_imm_i = 32'h7;
      step();
      redirect_valid_i = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      check("t4_misalign", 32'(misalign_o), 32'h1);
      check("t4_noreq", 32'(if_req_o), 32'h0);
      step(); check("t4_trap", 32'(if_req_o), 32'h0);
`else
      check("t4_addr", if_addr_o, 32'h106);
`endif

      // Async reset in the middle of a request
      apply_reset();
      redirect_valid_i = 1; redirect_op_i = OP_ADD;
      redirect_pc_i = 32'h40; redirect_imm_i = 32'h0; stall_i = 0; if_ack_i = 0;
      step(); check("t6_addr", if_addr_o, 32'h40);
      redirect_valid_i = 0;
      rst_i = 1; model_reset();
      #1;
      check("t6_req_async", 32'(if_req_o), 32'h0);
      check("t6_valid_async", 32'(inst_valid_o), 32'h0);
      @(posedge clk); #1; rst_i = 0;
      step(); check("t6_first_addr", if_addr_o, 32'h0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if (i % 300 == 0) apply_reset();
         stall_i          = ($urandom_range(0, 3) == 0);
         if_ack_i         = ($urandom_range(0, 2) == 0);
         inst_ready_i     = ($urandom_range(0, 1) == 1);
         redirect_valid_i = ($urandom_range(0, 7) == 0);
         redirect_op_i    = 2'($urandom_range(0, 3));
         redirect_pc_i    = $urandom & 32'hFFFF_FFFC;
         redirect_imm_i   = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
